// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt arbitration with flush, CP0 update and drain window
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        cp0_exc_we_o,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_bd_o,
  output logic        cp0_exl_set_o,
  output logic        cp0_exl_clr_o,
  output logic        busy_o
);
  typedef enum logic {S_IDLE, S_DRAIN} state_t;
  localparam logic [2:0] LP_DRAIN = 3'(DRAIN_CYCLES);
  state_t      r_state, w_state_nx;
  logic [2:0]  r_cnt, w_cnt_nx;
  logic        r_flush, r_exc_we, r_bd, r_exl_set, r_exl_clr;
  logic [31:0] r_new_pc, r_epc;
  logic [4:0]  r_exccode;
  logic [31:0] w_eff_status, w_eff_cause, w_eff_epc, w_epc_val;
  logic        w_int, w_exc, w_det, w_upd_epc;
  logic [4:0]  w_code;
  // CP0 forwarding from WB mtc0, interrupt check, priority encode
  always_comb begin
    w_eff_status = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_wdata_i : cp0_status_i;
    w_eff_epc    = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_wdata_i : cp0_epc_i;
    w_eff_cause  = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
                 ? {cp0_cause_i[31:24], wb_cp0_wdata_i[23:22], cp0_cause_i[21:10], wb_cp0_wdata_i[9:8], cp0_cause_i[7:0]}
                 : cp0_cause_i;
    w_int     = w_eff_status[0] && !w_eff_status[1] && |(w_eff_cause[15:8] & w_eff_status[15:8]);
    w_exc     = w_int || |exc_flags_i[3:0];
    w_det     = r_state == S_IDLE && inst_valid_i && (w_exc || exc_flags_i[4]);
    w_code    = w_int ? 5'h00 : exc_flags_i[3] ? 5'h08 : exc_flags_i[2] ? 5'h0A : exc_flags_i[1] ? 5'h0D : 5'h0C;
    w_upd_epc = w_det && w_exc && !w_eff_status[1];
    w_epc_val = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
  end
  // Next state: the drain count is held on the flush cycle, then counts down the quiet cycles
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == S_IDLE) begin
      w_state_nx = w_det ? S_DRAIN : S_IDLE;
      w_cnt_nx   = w_det ? LP_DRAIN : r_cnt;
    end else if (!r_flush) begin
      w_state_nx = (r_cnt == 3'd1) ? S_IDLE : S_DRAIN;
      w_cnt_nx   = r_cnt - 3'd1;
    end
  end
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  // Registered one-cycle responses; redirect PC holds between flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush   <= 1'b0;
      r_new_pc  <= 32'd0;
      r_exc_we  <= 1'b0;
      r_epc     <= 32'd0;
      r_exccode <= 5'd0;
      r_bd      <= 1'b0;
      r_exl_set <= 1'b0;
      r_exl_clr <= 1'b0;
    end else begin
      r_flush   <= w_det;
      r_new_pc  <= w_det ? (w_exc ? EXC_VECTOR : w_eff_epc) : r_new_pc;
      r_exc_we  <= w_det && w_exc;
      r_exl_set <= w_det && w_exc;
      r_exl_clr <= w_det && !w_exc;
      r_exccode <= (w_det && w_exc) ? w_code : 5'd0;
      r_epc     <= w_upd_epc ? w_epc_val : 32'd0;
      r_bd      <= w_upd_epc && in_delayslot_i;
    end
  end
  assign flush_o       = r_flush;
  assign new_pc_o      = r_new_pc;
  assign cp0_exc_we_o  = r_exc_we;
  assign cp0_epc_o     = r_epc;
  assign cp0_exccode_o = r_exccode;
  assign cp0_bd_o      = r_bd;
  assign cp0_exl_set_o = r_exl_set;
  assign cp0_exl_clr_o = r_exl_clr;
  assign busy_o        = r_state != S_IDLE;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and random checks of exc_ctrl against a cycle-level reference model
module tb_exc_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_valid_i = 1'b0, in_delayslot_i = 1'b0;
  logic [31:0] inst_addr_i = '0, cp0_status_i = '0, cp0_cause_i = '0, cp0_epc_i = '0, wb_cp0_wdata_i = '0;
  logic [4:0]  exc_flags_i = '0, wb_cp0_waddr_i = '0;
  logic        wb_cp0_we_i = 1'b0;
  logic        flush_o, cp0_exc_we_o, cp0_bd_o, cp0_exl_set_o, cp0_exl_clr_o, busy_o;
  logic [31:0] new_pc_o, cp0_epc_o;
  logic [4:0]  cp0_exccode_o;
  int checks = 0, failures = 0;
  int rem = 0;
  logic [31:0] m_pc = '0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .in_delayslot_i(in_delayslot_i), .exc_flags_i(exc_flags_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
    .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .cp0_exc_we_o(cp0_exc_we_o), .cp0_epc_o(cp0_epc_o),
    .cp0_exccode_o(cp0_exccode_o), .cp0_bd_o(cp0_bd_o), .cp0_exl_set_o(cp0_exl_set_o),
    .cp0_exl_clr_o(cp0_exl_clr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic ds, input logic [4:0] f,
                        input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
    inst_valid_i = v; inst_addr_i = a; in_delayslot_i = ds; exc_flags_i = f;
    cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
    wb_cp0_we_i = we; wb_cp0_waddr_i = wa; wb_cp0_wdata_i = wd;
  endtask

  task automatic idle_in();
    set_in(1'b0, '0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // One clock: model predicts from current inputs, DUT sampled 1 time unit after the edge
  task automatic step();
    logic [31:0] st, ca, ep, e_epc;
    logic irq, exc, det, e_bd;
    logic [4:0] code;
    st = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_wdata_i : cp0_status_i;
    ep = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_wdata_i : cp0_epc_i;
    ca = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
      ca[9:8]   = wb_cp0_wdata_i[9:8];
      ca[23:22] = wb_cp0_wdata_i[23:22];
    end
    irq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    exc = irq || (exc_flags_i[3:0] != 4'd0);
    det = (rem == 0) && inst_valid_i && (exc || exc_flags_i[4]);
    if (irq) code = 5'h00;
    else if (exc_flags_i[3]) code = 5'h08;
    else if (exc_flags_i[2]) code = 5'h0A;
    else if (exc_flags_i[1]) code = 5'h0D;
    else code = 5'h0C;
    if (!det || !exc) code = 5'h00;
    if (det) m_pc = exc ? 32'h20 : ep;
    e_epc = (det && exc && !st[1]) ? (in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i) : 32'd0;
    e_bd  = det && exc && !st[1] && in_delayslot_i;
    rem = det ? 4 : (rem > 0 ? rem - 1 : 0);
    @(posedge clk);
    #1;
    chk("flush", 32'(flush_o), 32'(det));
    chk("new_pc", new_pc_o, m_pc);
    chk("exc_we", 32'(cp0_exc_we_o), 32'(det && exc));
    chk("exl_set", 32'(cp0_exl_set_o), 32'(det && exc));
    chk("exl_clr", 32'(cp0_exl_clr_o), 32'(det && !exc));
    chk("exccode", 32'(cp0_exccode_o), 32'(code));
    chk("epc", cp0_epc_o, e_epc);
    chk("bd", 32'(cp0_bd_o), 32'(e_bd));
    chk("busy", 32'(busy_o), 32'(rem > 0));
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    logic [4:0] f;
    logic [4:0] wa;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pc", new_pc_o, 32'd0);
    chk("rst_we", 32'(cp0_exc_we_o), 32'd0);
    rst = 1'b0;
    // overflow, then flush cycle followed by three quiet busy cycles
    set_in(1'b1, 32'h100, 1'b0, 5'b00001, 32'h1000_0000, '0, '0, 1'b0, '0, '0);
    step();
    chk("ovf_flush", 32'(flush_o), 32'd1);
    chk("ovf_pc", new_pc_o, 32'h20);
    chk("ovf_code", 32'(cp0_exccode_o), 32'h0C);
    chk("ovf_epc", cp0_epc_o, 32'h100);
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_busy", 32'(busy_o), 32'd1);
      chk("drain_quiet", 32'(flush_o | cp0_exc_we_o | cp0_exl_set_o), 32'd0);
    end
    step();
    chk("drain_done", 32'(busy_o), 32'd0);
    // syscall + invalid_inst in delay slot, held through the drain
    set_in(1'b1, 32'h204, 1'b1, 5'b01100, '0, '0, '0, 1'b0, '0, '0);
    step();
    chk("sys_code", 32'(cp0_exccode_o), 32'h08);
    chk("sys_epc", cp0_epc_o, 32'h200);
    chk("sys_bd", 32'(cp0_bd_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sys_once", 32'(flush_o), 32'd0);
    end
    drain();
    // timer interrupt, then same with EXL set
    set_in(1'b1, 32'h300, 1'b0, '0, 32'h0000_8001, 32'h0000_8000, '0, 1'b0, '0, '0);
    step();
    chk("irq_flush", 32'(flush_o), 32'd1);
    chk("irq_code", 32'(cp0_exccode_o), 32'h00);
    chk("irq_epc", cp0_epc_o, 32'h300);
    drain();
    set_in(1'b1, 32'h300, 1'b0, '0, 32'h0000_8003, 32'h0000_8000, '0, 1'b0, '0, '0);
    step();
    chk("irq_exl", 32'(flush_o), 32'd0);
    // eret with EPC forwarded from WB
    set_in(1'b1, 32'h310, 1'b0, 5'b10000, 32'h0000_0003, '0, 32'h400, 1'b1, 5'd14, 32'h500);
    step();
    chk("eret_pc", new_pc_o, 32'h500);
    chk("eret_clr", 32'(cp0_exl_clr_o), 32'd1);
    chk("eret_we", 32'(cp0_exc_we_o), 32'd0);
    drain();
    // pending interrupt waits across bubbles
    set_in(1'b0, 32'h5FC, 1'b0, '0, 32'h0000_8001, 32'h0000_8000, '0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bubble", 32'(flush_o), 32'd0);
    end
    inst_valid_i = 1'b1; inst_addr_i = 32'h600;
    step();
    chk("bub_epc", cp0_epc_o, 32'h600);
    set_in(1'b1, 32'h604, 1'b0, 5'b00001, '0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_ign", 32'(flush_o), 32'd0);
    end
    drain();
    // delay slot at address 0 wraps the EPC
    set_in(1'b1, 32'h0, 1'b1, 5'b00010, '0, '0, '0, 1'b0, '0, '0);
    step();
    chk("wrap_epc", cp0_epc_o, 32'hFFFF_FFFC);
    drain();
    // asynchronous reset during the flush cycle
    set_in(1'b1, 32'h700, 1'b0, 5'b00001, '0, '0, '0, 1'b0, '0, '0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_flush", 32'(flush_o), 32'd0);
    rem = 0; m_pc = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    set_in(1'b1, 32'h800, 1'b0, 5'b00001, '0, '0, '0, 1'b0, '0, '0);
    step();
    chk("post_rst", cp0_epc_o, 32'h800);
    drain();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      f = '0;
      for (int b = 0; b < 5; b++) f[b] = ($urandom % 6) == 0;
      case ($urandom % 4)
        0: wa = 5'd12;
        1: wa = 5'd13;
        2: wa = 5'd14;
        default: wa = 5'($urandom);
      endcase
      set_in(($urandom % 4) != 0, ($urandom % 8 == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC),
             1'($urandom), f, $urandom, $urandom, $urandom, ($urandom % 3) == 0, wa, $urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
